// File: rtl/snake_nav_pkg.sv
// rtl/snake_nav_pkg.sv - direction encoding, button indices and turn helpers for the snake navigation controller
package snake_nav_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'b00;
  localparam dir_t DIR_LEFT  = 2'b01;
  localparam dir_t DIR_RIGHT = 2'b10;
  localparam dir_t DIR_DOWN  = 2'b11;

  localparam int MAX_PLAYERS     = 4;
  localparam int MAX_QUEUE_DEPTH = 4;

  // Bit positions of one player's buttons inside a 4-bit button vector.
  typedef enum logic [1:0] {
    BTN_U = 2'd0,
    BTN_D = 2'd1,
    BTN_L = 2'd2,
    BTN_R = 2'd3
  } btn_idx_e;

  typedef struct packed {
    logic valid;
    dir_t dir;
  } turn_req_t;

  // Reversal: the two directions differ in both bits.
  function automatic logic is_opposite(input dir_t a, input dir_t b);
    return (a ^ b) == 2'b11;
  endfunction

  // Vertical directions (00, 11) have equal bits, horizontal ones (01, 10) differ.
  function automatic logic is_perpendicular(input dir_t a, input dir_t b);
    return (a[1] ^ a[0]) != (b[1] ^ b[0]);
  endfunction

  // Reduce simultaneous presses to a single candidate, U > D > L > R.
  function automatic turn_req_t pick_turn(input logic [3:0] press);
    turn_req_t req;
    req.valid = 1'b1;
    if (press[BTN_U])      req.dir = DIR_UP;
    else if (press[BTN_D]) req.dir = DIR_DOWN;
    else if (press[BTN_L]) req.dir = DIR_LEFT;
    else if (press[BTN_R]) req.dir = DIR_RIGHT;
    else begin
      req.valid = 1'b0;
      req.dir   = DIR_UP;
    end
    return req;
  endfunction

endpackage

// File: rtl/snake_turn_queue.sv
// rtl/snake_turn_queue.sv - one player's edge detect, turn filter, turn FIFO, direction and overflow (optional SNAKE_NAV_DEBOUNCE_EN)
module snake_turn_queue
  import snake_nav_pkg::*;
#(
  parameter int   QUEUE_DEPTH = 2,
  parameter dir_t RESET_DIR   = DIR_UP
`ifdef SNAKE_NAV_DEBOUNCE_EN
  ,
  parameter int   DEBOUNCE_CYCLES = 16
`endif
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLEAR,
  input  logic       TICK,
  input  logic [3:0] btn,
  output dir_t       direction,
  output logic       pending,
  output logic       overflow
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(QUEUE_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);

  logic [3:0] level;
  logic [3:0] btn_q;
  logic [3:0] press;

`ifdef SNAKE_NAV_DEBOUNCE_EN
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]      sync1;
  logic [3:0]      sync2;
  logic [3:0]      filt;
  logic [DB_W-1:0] db_cnt [4];

  // Synchronise raw buttons, then let the filtered level follow only after a stable run.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1 <= '0;
      sync2 <= '0;
      filt  <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else if (CLEAR) begin
      sync1 <= '0;
      sync2 <= '0;
      filt  <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == filt[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          filt[i]   <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign level = filt;
`else
  assign level = btn;
`endif

  dir_t             mem [QUEUE_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [CNT_W-1:0] count;
  dir_t             cur_dir;
  logic             ovf_q;

  turn_req_t        req;
  dir_t             ref_dir;
  logic             accept;
  logic             do_pop;
  logic             do_push;
  logic             do_drop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Filter the candidate turn against the last queued direction and decide push/pop/drop.
  always_comb begin
    press    = level & ~btn_q;
    req      = pick_turn(press);
    tail_ptr = (wr_ptr == '0) ? LAST_PTR : wr_ptr - 1'b1;
    ref_dir  = (count != '0) ? mem[tail_ptr] : cur_dir;
    accept   = req.valid && is_perpendicular(req.dir, ref_dir);
    do_pop   = TICK && (count != '0);
    do_push  = accept && ((count != FULL_CNT) || do_pop);
    do_drop  = accept && (count == FULL_CNT) && !do_pop;
  end

  // Queue storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge CLK) begin
    if (do_push && !CLEAR) mem[wr_ptr] <= req.dir;
  end

  // Pointers, occupancy, current direction, sticky overflow and button history.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      cur_dir <= RESET_DIR;
      ovf_q   <= 1'b0;
      btn_q   <= '0;
    end else if (CLEAR) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      cur_dir <= RESET_DIR;
      ovf_q   <= 1'b0;
      btn_q   <= '0;
    end else begin
      btn_q <= level;
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) begin
        rd_ptr  <= ptr_inc(rd_ptr);
        cur_dir <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (do_drop) ovf_q <= 1'b1;
    end
  end

  assign direction = cur_dir;
  assign pending   = (count != '0);
  assign overflow  = ovf_q;

endmodule

// File: rtl/snake_multi_nav_controller.sv
// rtl/snake_multi_nav_controller.sv - multi-player snake direction controller with per-player turn queues (optional SNAKE_NAV_DEBOUNCE_EN)
module snake_multi_nav_controller
  import snake_nav_pkg::*;
#(
  parameter int         NUM_PLAYERS     = 2,
  parameter int         QUEUE_DEPTH     = 2,
  parameter logic [1:0] RESET_DIR       = 2'b00,
  parameter int         DEBOUNCE_CYCLES = 16
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     CLEAR,
  input  logic                     TICK,
  input  logic [NUM_PLAYERS-1:0]   BTNU,
  input  logic [NUM_PLAYERS-1:0]   BTND,
  input  logic [NUM_PLAYERS-1:0]   BTNL,
  input  logic [NUM_PLAYERS-1:0]   BTNR,
  output logic [2*NUM_PLAYERS-1:0] Direction_State,
  output logic [NUM_PLAYERS-1:0]   Turn_Pending,
  output logic [NUM_PLAYERS-1:0]   Overflow
);

  if (NUM_PLAYERS < 1 || NUM_PLAYERS > MAX_PLAYERS) begin : g_bad_players
    $error("NUM_PLAYERS out of range 1..4");
  end
  if (QUEUE_DEPTH < 1 || QUEUE_DEPTH > MAX_QUEUE_DEPTH) begin : g_bad_depth
    $error("QUEUE_DEPTH out of range 1..4");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
    snake_turn_queue #(
      .QUEUE_DEPTH     (QUEUE_DEPTH),
      .RESET_DIR       (RESET_DIR)
`ifdef SNAKE_NAV_DEBOUNCE_EN
      ,
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`endif
    ) u_turn_queue (
      .CLK       (CLK),
      .RESET     (RESET),
      .CLEAR     (CLEAR),
      .TICK      (TICK),
      .btn       ({BTNR[g], BTNL[g], BTND[g], BTNU[g]}),
      .direction (Direction_State[2*g +: 2]),
      .pending   (Turn_Pending[g]),
      .overflow  (Overflow[g])
    );
  end

endmodule

// File: tb/tb_snake_multi_nav_controller.sv
// tb/tb_snake_multi_nav_controller.sv - scoreboard bench with behavioural turn-queue model
module tb_snake_multi_nav_controller;

  localparam int         NP = 2;
  localparam int         QD = 2;
  localparam logic [1:0] RD = 2'b00;

  logic          CLK;
  logic          RESET;
  logic          CLEAR;
  logic          TICK;
  logic [NP-1:0] BTNU, BTND, BTNL, BTNR;
  logic [2*NP-1:0] Direction_State;
  logic [NP-1:0]   Turn_Pending;
  logic [NP-1:0]   Overflow;

  snake_multi_nav_controller #(
    .NUM_PLAYERS(NP), .QUEUE_DEPTH(QD), .RESET_DIR(RD), .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLK(CLK), .RESET(RESET), .CLEAR(CLEAR), .TICK(TICK),
    .BTNU(BTNU), .BTND(BTND), .BTNL(BTNL), .BTNR(BTNR),
    .Direction_State(Direction_State), .Turn_Pending(Turn_Pending), .Overflow(Overflow)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct packed {
    logic [2*NP-1:0] dir;
    logic [NP-1:0]   pend;
    logic [NP-1:0]   ov;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: per-player list of pending turns plus current direction.
  logic [1:0] m_cur  [NP];
  logic [1:0] m_q    [NP][$];
  logic       m_ov   [NP];
  logic [3:0] m_prev [NP];

  function automatic logic vertical(input logic [1:0] d);
    return (d == 2'b00) || (d == 2'b11);
  endfunction

  task automatic model_reset(input int p);
    m_cur[p]  = RD;
    m_q[p]    = {};
    m_ov[p]   = 1'b0;
    m_prev[p] = 4'b0;
  endtask

  task automatic step(input logic [NP-1:0] u, d, l, r, input logic tick, clr, rst);
    exp_t e;
    BTNU = u; BTND = d; BTNL = l; BTNR = r;
    TICK = tick; CLEAR = clr; RESET = rst;
    for (int p = 0; p < NP; p++) begin
      if (rst || clr) begin
        model_reset(p);
      end else begin
        logic [3:0] now;
        logic [3:0] pr;
        logic       have, acc, pop, add;
        logic [1:0] c, ref_d;
        now = {r[p], l[p], d[p], u[p]};
        pr  = now & ~m_prev[p];
        have = 1'b1;
        c    = 2'b00;
        if (pr[0])      c = 2'b00;
        else if (pr[1]) c = 2'b11;
        else if (pr[2]) c = 2'b01;
        else if (pr[3]) c = 2'b10;
        else have = 1'b0;
        ref_d = (m_q[p].size() > 0) ? m_q[p][$] : m_cur[p];
        acc = have && (vertical(c) != vertical(ref_d));
        pop = tick && (m_q[p].size() > 0);
        add = 1'b0;
        if (acc) begin
          if (m_q[p].size() < QD || pop) add = 1'b1;
          else m_ov[p] = 1'b1;
        end
        if (pop) m_cur[p] = m_q[p].pop_front();
        if (add) m_q[p].push_back(c);
        m_prev[p] = now;
      end
    end
    for (int p = 0; p < NP; p++) begin
      e.dir[2*p +: 2] = m_cur[p];
      e.pend[p]       = (m_q[p].size() > 0);
      e.ov[p]         = m_ov[p];
    end
    sb.push_back(e);
    @(posedge CLK);
    #2;
  endtask

  task automatic idle();
    step('0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic tk();
    step('0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic clr();
    step('0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents a new registered state; compare against the oldest expectation.
  always @(posedge CLK) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks += 3;
      if (Direction_State !== e.dir) begin
        errors++;
        $display("FAIL sb_dir t=%0t actual=%b expected=%b", $time, Direction_State, e.dir);
      end
      if (Turn_Pending !== e.pend) begin
        errors++;
        $display("FAIL sb_pend t=%0t actual=%b expected=%b", $time, Turn_Pending, e.pend);
      end
      if (Overflow !== e.ov) begin
        errors++;
        $display("FAIL sb_ovf t=%0t actual=%b expected=%b", $time, Overflow, e.ov);
      end
    end
  end

  initial begin
    BTNU = '0; BTND = '0; BTNL = '0; BTNR = '0;
    TICK = 1'b0; CLEAR = 1'b0; RESET = 1'b1;
    step('0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    step('0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("reset_dir", 8'(Direction_State), 8'h00);
    chk("reset_pend", 8'(Turn_Pending), 8'h00);
    chk("reset_ovf", 8'(Overflow), 8'h00);

    // Single turn left then TICK.
    idle();
    step('0, '0, 2'b01, '0, 1'b0, 1'b0, 1'b0);
    chk("t1_pend_after_press", 8'(Turn_Pending[0]), 8'h01);
    chk("t1_dir_before_tick", 8'(Direction_State[1:0]), 8'h00);
    tk();
    chk("t1_dir_after_tick", 8'(Direction_State[1:0]), 8'h01);
    chk("t1_pend_after_tick", 8'(Turn_Pending[0]), 8'h00);

    // Reversal and same-direction presses are ignored.
    clr();
    step('0, 2'b01, '0, '0, 1'b0, 1'b0, 1'b0);
    idle();
    step(2'b01, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    idle();
    tk(); tk(); tk();
    chk("t2_dir", 8'(Direction_State[1:0]), 8'h00);
    chk("t2_pend", 8'(Turn_Pending[0]), 8'h00);
    chk("t2_ovf", 8'(Overflow[0]), 8'h00);

    // Full queue drops the third turn and sets sticky overflow.
    clr();
    step('0, '0, 2'b01, '0, 1'b0, 1'b0, 1'b0); idle();
    step(2'b01, '0, '0, '0, 1'b0, 1'b0, 1'b0); idle();
    step('0, '0, '0, 2'b01, 1'b0, 1'b0, 1'b0); idle();
    chk("t3_ovf_set", 8'(Overflow[0]), 8'h01);
    tk();
    chk("t3_dir_first", 8'(Direction_State[1:0]), 8'h01);
    tk();
    chk("t3_dir_second", 8'(Direction_State[1:0]), 8'h00);
    chk("t3_pend_empty", 8'(Turn_Pending[0]), 8'h00);
    chk("t3_ovf_sticky", 8'(Overflow[0]), 8'h01);
    clr();
    chk("t3_ovf_cleared", 8'(Overflow[0]), 8'h00);

    // Full queue with press and TICK together accepts the push.
    step('0, '0, 2'b01, '0, 1'b0, 1'b0, 1'b0); idle();
    step(2'b01, '0, '0, '0, 1'b0, 1'b0, 1'b0); idle();
    step('0, '0, '0, 2'b01, 1'b1, 1'b0, 1'b0);
    chk("t4_dir_pop", 8'(Direction_State[1:0]), 8'h01);
    chk("t4_ovf_clear", 8'(Overflow[0]), 8'h00);
    tk();
    chk("t4_dir_up", 8'(Direction_State[1:0]), 8'h00);
    tk();
    chk("t4_dir_right", 8'(Direction_State[1:0]), 8'h02);
    chk("t4_pend_empty", 8'(Turn_Pending[0]), 8'h00);

    // Priority: P1 presses U+R while heading up, U wins and is ignored.
    clr();
    step(2'b10, '0, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0);
    chk("t5_pend_vec", 8'(Turn_Pending), 8'h01);
    tk();
    chk("t5_dir_vec", 8'(Direction_State), 8'h01);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [NP-1:0] u, d, l, r;
      u = BTNU; d = BTND; l = BTNL; r = BTNR;
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 3) == 0) u[p] = ~u[p];
        if ($urandom_range(0, 3) == 0) d[p] = ~d[p];
        if ($urandom_range(0, 3) == 0) l[p] = ~l[p];
        if ($urandom_range(0, 3) == 0) r[p] = ~r[p];
      end
      step(u, d, l, r,
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 149) == 0),
           ($urandom_range(0, 399) == 0));
    end
    idle();
    idle();

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain actual=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/snake_multi_nav_controller.md
Name: snake_multi_nav_controller

Overview:
- Parametrised successor of the single-player direction FSM.
- Serves NUM_PLAYERS snakes, each from its own four buttons.
- Turns are rising-edge triggered, filtered (no reversal, no same-direction), and buffered in a per-player turn queue.
- The queue is drained one entry per game TICK, so quick multi-press sequences between movement steps are kept in order.
- Sits between the button inputs and the snake position/update logic.

Parameters:
- NUM_PLAYERS, 2, number of independent snakes/button sets (1..4).
- QUEUE_DEPTH, 2, pending turns held per player (1..4, power of two not required).
- RESET_DIR, 2'b00, direction loaded at reset/CLEAR (all players).
- DEBOUNCE_CYCLES, 16, button stable time in CLK cycles (used only with DEBOUNCE_EN).

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- CLEAR  in  1  synchronous game restart; same effect as reset on state.
- TICK  in  1  one-cycle pulse, snake movement step.
- BTNU  in  NUM_PLAYERS  up button, bit p = player p.
- BTND  in  NUM_PLAYERS  down button.
- BTNL  in  NUM_PLAYERS  left button.
- BTNR  in  NUM_PLAYERS  right button.
- Direction_State  out  2*NUM_PLAYERS  current direction; bits [2p+1:2p] = player p.
- Turn_Pending  out  NUM_PLAYERS  queue of player p non-empty.
- Overflow  out  NUM_PLAYERS  sticky; a valid turn was dropped because the queue was full.

Behaviour:
- Encoding: 00 up, 01 left, 10 right, 11 down. Opposite(d) = d ^ 2'b11. Vertical = {00,11}; horizontal = {01,10}.
- Reset (async) or CLEAR (sync):
  - Direction_State = RESET_DIR per player.
  - Queues emptied; Turn_Pending = 0; Overflow = 0.
  - Button edge registers loaded with 0.
  - A button held through reset produces an edge one cycle after release of reset.
- Edge detect: press = button & ~button_q, where button_q is the registered previous value. Only presses act; holding does nothing further.
- Multiple presses for one player in one cycle: priority U > D > L > R. Only one candidate is considered per cycle.
- Reference direction R = queue tail if queue non-empty, else current direction.
- Candidate accepted only if it is perpendicular to R. Same direction or opposite (reversal) is silently ignored; Overflow is unaffected.
- Accepted and queue not full -> push, visible on Turn_Pending the next cycle.
- Accepted and queue full -> dropped; Overflow[p] set the next cycle and held until reset/CLEAR.
- TICK with queue non-empty -> pop head into current direction. Direction_State updates on the clock edge that samples TICK, visible the next cycle.
- TICK with queue empty -> no change.
- Simultaneous push and pop in one cycle:
  - Both occur; occupancy unchanged.
  - R is still computed from the pre-pop tail, which equals the new current direction if depth was 1.
  - A full queue with pop in the same cycle accepts the push (no overflow).
- CLEAR has priority over TICK and presses in the same cycle.
- Players are fully independent; no shared state except CLK/RESET/CLEAR/TICK.
- All outputs are registered; no combinational path from buttons to outputs.

Optional Feature:
- Macro SNAKE_NAV_DEBOUNCE_EN.
- Defined: each button passes a 2-flop synchroniser and then a stability counter. The filtered level changes only after the raw input is stable for DEBOUNCE_CYCLES consecutive cycles. Edge detect runs on the filtered level, so press-to-queue latency is 2 + DEBOUNCE_CYCLES + 1 cycles.
- Undefined: raw buttons feed edge detect directly; latency is 1 cycle. The DEBOUNCE_CYCLES parameter is ignored.

Decomposition:
- Package snake_nav_pkg holds:
  - direction constants DIR_UP/DIR_LEFT/DIR_RIGHT/DIR_DOWN;
  - a 2-bit dir_t typedef;
  - functions is_opposite and is_perpendicular.
- Sub-module snake_turn_queue: one player's edge detect, filter, FIFO, current-direction register and overflow flag. It is instantiated NUM_PLAYERS times in a generate loop.

Test Plan:
- Reset, RESET_DIR=00; P0 press L, then TICK -> Turn_Pending[0]=1 after press; Direction_State[1:0]=01 the cycle after TICK; Turn_Pending[0]=0.
- Current 00, press D (reversal) then U (same) -> queue stays empty, Overflow=0, direction stays 00 across 3 TICKs.
- QUEUE_DEPTH=2, current 00: press L, U, R (no TICK) -> queue {01,00}; R dropped, Overflow[0]=1. Two TICKs -> directions 01 then 00; Overflow stays 1 until CLEAR.
- Queue full {01,00} with R press and TICK in the same cycle -> push accepted against tail 00, Overflow=0, queue {00,10}.
- P0 presses L, and P1 presses U+R simultaneously while current is 00 -> P0 queues 01. P1: U wins priority, is same-direction, so ignored; P1 queue stays empty.
- With SNAKE_NAV_DEBOUNCE_EN, DEBOUNCE_CYCLES=4: a 3-cycle glitch on BTNL -> no push; a 10-cycle press -> exactly one push 7 cycles after assertion.
